// File: rtl/bus_control_sequencer.sv
// Control-step sequencer for the shared 32-bit datapath bus.
// Runs fetch (T0-T2) and execute (T3-T6) and drives every bus
// source enable and register load enable, one bus source per cycle.
//
// Ports:
//   clk, clear_n           clock, synchronous active-low reset
//   start                  begin one instruction (honoured only in IDLE)
//   mem_ready              memory read data valid this cycle
//   ir[31:0]               IR contents: op[31:27] Ra[26:23] Rb[22:19] Rc[18:15]
//   busy, done, error      status; done/error are 1-cycle pulses
//   pc_out .. r_out, r_sel bus source enables and register source index
//   mar_in .. r_in,rin_sel load enables and register destination index
//   read, inc_pc, alu_op   memory strobe, PC+1 select, ALU function
module bus_control_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int ALU_OP_W    = 5
) (
    input  logic                clk,
    input  logic                clear_n,
    input  logic                start,
    input  logic                mem_ready,
    input  logic [31:0]         ir,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic                pc_out,
    output logic                zlo_out,
    output logic                zhi_out,
    output logic                mdr_out,
    output logic                r_out,
    output logic [3:0]          r_sel,
    output logic                mar_in,
    output logic                pc_in,
    output logic                mdr_in,
    output logic                ir_in,
    output logic                y_in,
    output logic                z_in,
    output logic                hi_in,
    output logic                lo_in,
    output logic                r_in,
    output logic [3:0]          rin_sel,
    output logic                read,
    output logic                inc_pc,
    output logic [ALU_OP_W-1:0] alu_op
);

    localparam int CW0 = $clog2(MEM_TIMEOUT + 1);
    localparam int CW  = (CW0 < 4) ? 4 : CW0;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [4:0]    op_q;
    logic [3:0]    ra_q, rb_q, rc_q;

    logic [4:0] ir_op;
    logic [3:0] ir_rb;
    logic       ir_legal, ir_unary;
    logic       q_muldiv, q_unary;
    logic       timeout;
    logic       unused_ir;

    assign ir_op     = ir[31:27];
    assign ir_rb     = ir[22:19];
    assign unused_ir = ^ir[14:0];

    assign ir_legal = (ir_op <= 5'd8) || (ir_op >= 5'd15 && ir_op <= 5'd18);
    assign ir_unary = (ir_op == 5'd17) || (ir_op == 5'd18);
    assign q_muldiv = (op_q == 5'd15) || (op_q == 5'd16);
    assign q_unary  = (op_q == 5'd17) || (op_q == 5'd18);

    // Last T1 cycle allowed before the read is abandoned.
    assign timeout = (state == S_T1) && !mem_ready && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            op_q  <= '0;
            ra_q  <= '0;
            rb_q  <= '0;
            rc_q  <= '0;
        end else begin
            unique case (state)
                S_IDLE: if (start) state <= S_T0;
                S_T0: begin
                    cnt   <= '0;
                    state <= S_T1;
                end
                S_T1: begin
                    if (mem_ready)    state <= S_T2;
                    else if (timeout) state <= S_IDLE;
                    else              cnt   <= cnt + 1'b1;
                end
                S_T2: state <= S_T3;
                S_T3: begin
                    op_q  <= ir_op;
                    ra_q  <= ir[26:23];
                    rb_q  <= ir_rb;
                    rc_q  <= ir[18:15];
                    state <= ir_legal ? S_T4 : S_IDLE;
                end
                S_T4: state <= S_T5;
                S_T5: state <= q_muldiv ? S_T6 : S_IDLE;
                S_T6: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Every output is a decode of the current step; only mdr_in and
    // the timeout error also look at mem_ready within T1.
    always_comb begin
        busy    = (state != S_IDLE);
        done    = 1'b0;
        error   = 1'b0;
        pc_out  = 1'b0;
        zlo_out = 1'b0;
        zhi_out = 1'b0;
        mdr_out = 1'b0;
        r_out   = 1'b0;
        r_sel   = '0;
        mar_in  = 1'b0;
        pc_in   = 1'b0;
        mdr_in  = 1'b0;
        ir_in   = 1'b0;
        y_in    = 1'b0;
        z_in    = 1'b0;
        hi_in   = 1'b0;
        lo_in   = 1'b0;
        r_in    = 1'b0;
        rin_sel = '0;
        read    = 1'b0;
        inc_pc  = 1'b0;
        alu_op  = '0;
        unique case (state)
            S_IDLE: ;
            S_T0: begin
                pc_out = 1'b1;
                mar_in = 1'b1;
                inc_pc = 1'b1;
                z_in   = 1'b1;
            end
            S_T1: begin
                zlo_out = 1'b1;
                pc_in   = (cnt == '0);
                read    = 1'b1;
                mdr_in  = mem_ready;
                error   = timeout;
            end
            S_T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            S_T3: begin
                if (!ir_legal) begin
                    error = 1'b1;
                end else if (!ir_unary) begin
                    r_out = 1'b1;
                    r_sel = ir_rb;
                    y_in  = 1'b1;
                end
            end
            S_T4: begin
                r_out  = 1'b1;
                z_in   = 1'b1;
                alu_op = ALU_OP_W'(op_q);
                if (q_muldiv)     r_sel = ra_q;
                else if (q_unary) r_sel = rb_q;
                else              r_sel = rc_q;
            end
            S_T5: begin
                zlo_out = 1'b1;
                if (q_muldiv) begin
                    lo_in = 1'b1;
                end else begin
                    r_in    = 1'b1;
                    rin_sel = ra_q;
                    done    = 1'b1;
                end
            end
            S_T6: begin
                zhi_out = 1'b1;
                hi_in   = 1'b1;
                done    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
